rr_arbiter: RTL and testbench
=============================

# rr_arbiter

Round-robin arbiter that shares one resource, such as the LED/decoder datapath, among up to 16 requesters. It issues a registered one-hot grant in decoder form and its binary index in encoder form. The owner may hold the grant for at most MAX_HOLD cycles. It sits between the switch/key request sources and the shared datapath, in place of the direct encoder hookup.

## Interface
- N_REQ, 16, number of requesters; power of two, 2..16
- IDX_W, 4, log2(N_REQ); width of grant_idx
- MAX_HOLD, 255, maximum consecutive cycles one owner keeps grant_valid high; 1..2^HOLD_W-1
- HOLD_W, 8, width of hold counter

- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- enable  in  1  arbitration enable; low aborts current grant
- req  in  N_REQ  per-requester request level
- grant  out  N_REQ  one-hot grant, registered; all-zero when idle
- grant_idx  out  IDX_W  binary index of granted requester; 0 when grant_valid low
- grant_valid  out  1  high while a grant is held
- timeout  out  1  one-cycle pulse on forced release

## Operation
- Two states:
  - IDLE: no grant.
  - BUSY: grant held by owner.
- Internal registers:
  - ptr (IDX_W): search start point.
  - mask (N_REQ): timed-out requesters.
  - hold_cnt (HOLD_W).
- Reset values:
  - State IDLE, ptr=0, mask=0, hold_cnt=0.
  - grant=0, grant_idx=0, grant_valid=0, timeout=0.
- Eligibility: eligible[i] = req[i] & ~mask[i].
- IDLE, when enable=1 and any eligible bit is set:
  - Winner is the first eligible index found scanning ptr, ptr+1, … with wrap N_REQ-1 → 0.
  - Go to BUSY: grant=1<<winner, grant_idx=winner, grant_valid=1, hold_cnt=1.
- IDLE, when no eligible request or enable=0: stay IDLE, all outputs 0.
- BUSY, in this priority order:
  - enable=0 (abort): go IDLE, clear grant. ptr and mask unchanged; no timeout pulse.
  - req[owner]=0 (normal release): go IDLE, clear grant, ptr=(owner+1) mod N_REQ.
  - hold_cnt==MAX_HOLD with req[owner]=1 (forced release): go IDLE, clear grant, ptr=(owner+1) mod N_REQ, mask[owner]=1, timeout=1 for that one cycle.
  - Otherwise: hold grant, hold_cnt+1.
- Mask clearing: mask[i] clears on any edge where req[i] is sampled 0. A timed-out requester must drop req for at least one cycle before it is eligible again.
- Simultaneous owner release and hold_cnt==MAX_HOLD: treated as a normal release; no timeout pulse, no mask.
- grant is always one-hot or zero. grant_idx always equals the encoded grant.

## Timing
- Request latency: a req sampled at edge k in IDLE gives grant_valid high from edge k (visible cycle k+1). This is 1-cycle latency.
- Release latency: owner's req sampled low at edge m drops grant at edge m.
- Dead cycle: at least one cycle with grant_valid=0 between consecutive owners. The next grant is issued at edge m+1 at the earliest.
- Hold limit: grant_valid is high for at most MAX_HOLD consecutive cycles per grant.
- timeout pulse: coincides with the first cycle grant_valid is low after a forced release.
- Reset mid-operation: any state goes to the reset values at the next edge. No grant is issued in the cycle reset is sampled high.
- enable is sampled every edge. An abort takes effect at the same edge it is sampled low.

## Test plan
- Reset with req=16'h0000 → all outputs 0. Then req=16'h0001 → after one edge grant=16'h0001, grant_idx=0, grant_valid=1.
- req=16'hFFFF; each owner drops its req for one cycle after 2 granted cycles, then reasserts → grant_idx sequence 0,1,…,15,0 with exactly one grant_valid=0 cycle between owners.
- Owner 14 releases, then req=16'h0001 (bit 15 low) → wrap search grants index 0 (grant=16'h0001).
- MAX_HOLD=4, req=16'h0060 held constant, owner 5 → grant_valid high 4 cycles, timeout=1 for one cycle, then grant_idx=6. Index 5 is not regranted until req[5] drops for one cycle and reasserts.
- Owner 3 in BUSY, enable=0 for one cycle → grant=0 next edge, timeout=0. With enable=1 and req=16'h0008 held → index 3 regranted (ptr unchanged).
- Reset asserted while owner 9 is in BUSY → all outputs 0 at next edge. After reset, req=16'h8001 → grant_idx=0.

Source files
------------

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter sharing one resource among up to 16 requesters.
// Registered one-hot grant plus binary index; each owner keeps the grant for at most
// MAX_HOLD cycles, after which it is forced off and masked until it drops its request.
module rr_arbiter #(
  parameter int unsigned N_REQ    = 16,
  parameter int unsigned IDX_W    = 4,
  parameter int unsigned MAX_HOLD = 255,
  parameter int unsigned HOLD_W   = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic             timeout
);

  localparam logic [0:0]        IDLE       = 1'b0;
  localparam logic [0:0]        BUSY       = 1'b1;
  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);
  localparam logic [N_REQ-1:0]  BIT0       = N_REQ'(1);
  localparam logic [IDX_W-1:0]  IDX_ONE    = IDX_W'(1);

  logic [0:0]        state_q;
  logic [0:0]        state_d;
  logic [IDX_W-1:0]  ptr_q;
  logic [IDX_W-1:0]  ptr_d;
  logic [N_REQ-1:0]  mask_q;
  logic [N_REQ-1:0]  mask_d;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_d;
  logic [N_REQ-1:0]  grant_d;
  logic [IDX_W-1:0]  grant_idx_d;
  logic              grant_valid_d;
  logic              timeout_d;

  logic [N_REQ-1:0]  eligible;
  logic [IDX_W-1:0]  cand;
  logic [IDX_W-1:0]  winner;
  logic              found;
  logic              owner_req;
  logic [IDX_W-1:0]  next_ptr;

  // Requesters that may win this edge: requesting and not serving a timeout penalty.
  always_comb begin
    eligible  = req & ~mask_q;
    owner_req = req[grant_idx];
    next_ptr  = grant_idx + IDX_ONE;
  end

  // Circular search for the first eligible index starting at ptr; wrap is free
  // because N_REQ is a power of two and cand is IDX_W bits wide.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      cand = ptr_q + IDX_W'(off);
      if (!found && eligible[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    mask_d        = mask_q & req;
    hold_d        = hold_cnt;
    grant_d       = grant;
    grant_idx_d   = grant_idx;
    grant_valid_d = grant_valid;
    timeout_d     = 1'b0;

    case (state_q)
      IDLE: begin
        grant_d       = '0;
        grant_idx_d   = '0;
        grant_valid_d = 1'b0;
        hold_d        = '0;
        if (enable && found) begin
          state_d       = BUSY;
          grant_d       = BIT0 << winner;
          grant_idx_d   = winner;
          grant_valid_d = 1'b1;
          hold_d        = HOLD_ONE;
        end
      end
      BUSY: begin
        if (!enable) begin
          // Abort: drop the grant, search point and penalties untouched.
          state_d       = IDLE;
          grant_d       = '0;
          grant_idx_d   = '0;
          grant_valid_d = 1'b0;
          hold_d        = '0;
        end else if (!owner_req) begin
          // Normal release, also taken when it coincides with the hold limit.
          state_d       = IDLE;
          grant_d       = '0;
          grant_idx_d   = '0;
          grant_valid_d = 1'b0;
          hold_d        = '0;
          ptr_d         = next_ptr;
        end else if (hold_cnt == HOLD_LIMIT) begin
          // Forced release: penalise the owner until it drops its request.
          state_d       = IDLE;
          grant_d       = '0;
          grant_idx_d   = '0;
          grant_valid_d = 1'b0;
          hold_d        = '0;
          ptr_d         = next_ptr;
          mask_d        = mask_d | (BIT0 << grant_idx);
          timeout_d     = 1'b1;
        end else begin
          hold_d = hold_cnt + HOLD_ONE;
        end
      end
      default: begin
        state_d       = IDLE;
        grant_d       = '0;
        grant_idx_d   = '0;
        grant_valid_d = 1'b0;
        hold_d        = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      mask_q      <= '0;
      hold_cnt    <= '0;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      mask_q      <= mask_d;
      hold_cnt    <= hold_d;
      grant       <= grant_d;
      grant_idx   <= grant_idx_d;
      grant_valid <= grant_valid_d;
      timeout     <= timeout_d;
    end
  end

  // Structural invariants of the grant outputs.
  a_grant_onehot0: assert property (@(posedge clock) disable iff (reset)
    $onehot0(grant));
  a_grant_encoded: assert property (@(posedge clock) disable iff (reset)
    grant_valid |-> (grant == (BIT0 << grant_idx)));
  a_idle_zero: assert property (@(posedge clock) disable iff (reset)
    !grant_valid |-> (grant == '0 && grant_idx == '0));
  a_hold_bound: assert property (@(posedge clock) disable iff (reset)
    hold_cnt <= HOLD_LIMIT);

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: scenario tasks push expected grant indices into a queue
// when they drive requests and pop them when a grant appears on the outputs.
module tb_rr_arbiter;

  logic        clock;
  logic        reset;
  logic        enable;
  logic [15:0] req;
  logic [15:0] grant;
  logic [3:0]  grant_idx;
  logic        grant_valid;
  logic        timeout;

  int unsigned tests_run    = 0;
  int unsigned tests_failed = 0;
  int unsigned exp_idx_q[$];

  rr_arbiter #(
    .N_REQ(16), .IDX_W(4), .MAX_HOLD(4), .HOLD_W(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .req(req),
    .grant(grant),
    .grant_idx(grant_idx),
    .grant_valid(grant_valid),
    .timeout(timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    req    = '0;
    enable = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    int unsigned e;
    reset = 1'b1; req = '0; enable = 1'b1;
    tick();
    tick();
    tests_run++;
    if (grant !== 16'h0 || grant_idx !== 4'd0 || grant_valid !== 1'b0 || timeout !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got grant=%h idx=%0d valid=%b timeout=%b, want all 0",
               grant, grant_idx, grant_valid, timeout);
    end
    reset = 1'b0; req = 16'h0001;
    exp_idx_q.push_back(0);
    tick();
    e = exp_idx_q.pop_front();
    tests_run++;
    if (grant_valid !== 1'b1 || grant_idx !== 4'(e) || grant !== (16'(1) << e)) begin
      tests_failed++;
      $display("FAIL first_grant: got grant=%h idx=%0d valid=%b, want grant=%h idx=%0d valid=1",
               grant, grant_idx, grant_valid, 16'(1) << e, e);
    end
    req = '0;
    tick();
  endtask

  task automatic test_round_robin();
    int unsigned e;
    int unsigned got = 0;
    int unsigned held = 0;
    int unsigned gap = 0;
    bit          seen_first = 1'b0;
    logic [3:0]  cur = '0;
    do_reset();
    for (int i = 0; i <= 16; i++) exp_idx_q.push_back(int'(i % 16));
    req = 16'hFFFF;
    for (int cyc = 0; cyc < 200 && got < 17; cyc++) begin
      tick();
      if (grant_valid === 1'b1) begin
        if (held == 0 || grant_idx !== cur) begin
          e = exp_idx_q.pop_front();
          tests_run++;
          if (grant_idx !== 4'(e) || grant !== (16'(1) << e)) begin
            tests_failed++;
            $display("FAIL rr_order: got idx=%0d grant=%h, want idx=%0d grant=%h",
                     grant_idx, grant, e, 16'(1) << e);
          end
          if (seen_first) begin
            tests_run++;
            if (gap != 1) begin
              tests_failed++;
              $display("FAIL rr_dead_cycle: got %0d idle cycles before idx %0d, want 1", gap, grant_idx);
            end
          end
          seen_first = 1'b1;
          gap  = 0;
          held = 0;
          cur  = grant_idx;
          got++;
        end
        held++;
        if (held == 2) req = 16'hFFFF & ~(16'(1) << grant_idx);
      end else begin
        held = 0;
        gap++;
        req = 16'hFFFF;
      end
    end
    tests_run++;
    if (got != 17) begin
      tests_failed++;
      $display("FAIL rr_complete: got %0d grants, want 17", got);
      exp_idx_q.delete();
    end
    req = '0;
    tick();
    tick();
  endtask

  task automatic test_wrap();
    int unsigned e;
    do_reset();
    req = 16'h4000;
    exp_idx_q.push_back(14);
    tick();
    e = exp_idx_q.pop_front();
    tests_run++;
    if (grant_valid !== 1'b1 || grant_idx !== 4'(e) || grant !== (16'(1) << e)) begin
      tests_failed++;
      $display("FAIL wrap_owner14: got idx=%0d grant=%h valid=%b, want idx=%0d", grant_idx, grant, grant_valid, e);
    end
    req = 16'h0001;
    exp_idx_q.push_back(0);
    tick();
    tests_run++;
    if (grant_valid !== 1'b0 || grant !== 16'h0) begin
      tests_failed++;
      $display("FAIL wrap_dead_cycle: got valid=%b grant=%h, want valid=0 grant=0000", grant_valid, grant);
    end
    tick();
    e = exp_idx_q.pop_front();
    tests_run++;
    if (grant_valid !== 1'b1 || grant_idx !== 4'(e) || grant !== 16'h0001) begin
      tests_failed++;
      $display("FAIL wrap_grant0: got idx=%0d grant=%h valid=%b, want idx=0 grant=0001", grant_idx, grant, grant_valid);
    end
    req = '0;
    tick();
  endtask

  task automatic test_timeout();
    int unsigned e;
    int unsigned high_cycles;
    bit          stray;
    do_reset();
    req = 16'h0060;
    exp_idx_q.push_back(5);
    tick();
    e = exp_idx_q.pop_front();
    tests_run++;
    if (grant_valid !== 1'b1 || grant_idx !== 4'(e) || grant !== (16'(1) << e)) begin
      tests_failed++;
      $display("FAIL to_first_grant: got idx=%0d grant=%h valid=%b, want idx=%0d", grant_idx, grant, grant_valid, e);
    end
    high_cycles = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (grant_valid === 1'b1 && grant_idx === 4'd5) high_cycles++;
      else break;
    end
    tests_run++;
    if (high_cycles != 4) begin
      tests_failed++;
      $display("FAIL to_hold_cycles: got %0d cycles held, want 4", high_cycles);
    end
    tests_run++;
    if (timeout !== 1'b1 || grant_valid !== 1'b0 || grant !== 16'h0) begin
      tests_failed++;
      $display("FAIL to_pulse: got timeout=%b valid=%b grant=%h, want timeout=1 valid=0 grant=0000",
               timeout, grant_valid, grant);
    end
    exp_idx_q.push_back(6);
    tick();
    e = exp_idx_q.pop_front();
    tests_run++;
    if (grant_valid !== 1'b1 || grant_idx !== 4'(e) || timeout !== 1'b0) begin
      tests_failed++;
      $display("FAIL to_next_owner: got idx=%0d valid=%b timeout=%b, want idx=%0d valid=1 timeout=0",
               grant_idx, grant_valid, timeout, e);
    end
    for (int i = 0; i < 4; i++) tick();
    tests_run++;
    if (timeout !== 1'b1 || grant_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL to_second_pulse: got timeout=%b valid=%b, want timeout=1 valid=0", timeout, grant_valid);
    end
    stray = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (grant_valid !== 1'b0 || timeout !== 1'b0) stray = 1'b1;
    end
    tests_run++;
    if (stray) begin
      tests_failed++;
      $display("FAIL to_masked_idle: got a grant or pulse while both requesters masked, want none");
    end
    req = 16'h0040;
    tick();
    tests_run++;
    if (grant_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL to_mask6_held: got valid=%b idx=%0d, want valid=0", grant_valid, grant_idx);
    end
    req = 16'h0060;
    exp_idx_q.push_back(5);
    tick();
    e = exp_idx_q.pop_front();
    tests_run++;
    if (grant_valid !== 1'b1 || grant_idx !== 4'(e) || grant !== (16'(1) << e)) begin
      tests_failed++;
      $display("FAIL to_regrant5: got idx=%0d grant=%h valid=%b, want idx=%0d", grant_idx, grant, grant_valid, e);
    end
    req = '0;
    tick();
    tick();
  endtask

  task automatic test_release_at_limit();
    int unsigned e;
    do_reset();
    req = 16'h0004;
    exp_idx_q.push_back(2);
    tick();
    e = exp_idx_q.pop_front();
    tests_run++;
    if (grant_valid !== 1'b1 || grant_idx !== 4'(e)) begin
      tests_failed++;
      $display("FAIL lim_grant: got idx=%0d valid=%b, want idx=%0d valid=1", grant_idx, grant_valid, e);
    end
    for (int i = 0; i < 3; i++) tick();
    req = '0;
    tick();
    tests_run++;
    if (timeout !== 1'b0 || grant_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL lim_no_timeout: got timeout=%b valid=%b, want timeout=0 valid=0", timeout, grant_valid);
    end
    req = 16'h0004;
    exp_idx_q.push_back(2);
    tick();
    e = exp_idx_q.pop_front();
    tests_run++;
    if (grant_valid !== 1'b1 || grant_idx !== 4'(e)) begin
      tests_failed++;
      $display("FAIL lim_not_masked: got idx=%0d valid=%b, want idx=%0d valid=1", grant_idx, grant_valid, e);
    end
    req = '0;
    tick();
  endtask

  task automatic test_abort();
    int unsigned e;
    do_reset();
    req = 16'h0008;
    exp_idx_q.push_back(3);
    tick();
    e = exp_idx_q.pop_front();
    tests_run++;
    if (grant_valid !== 1'b1 || grant_idx !== 4'(e)) begin
      tests_failed++;
      $display("FAIL ab_grant: got idx=%0d valid=%b, want idx=%0d valid=1", grant_idx, grant_valid, e);
    end
    tick();
    enable = 1'b0;
    tick();
    tests_run++;
    if (grant !== 16'h0 || grant_valid !== 1'b0 || grant_idx !== 4'd0 || timeout !== 1'b0) begin
      tests_failed++;
      $display("FAIL ab_clear: got grant=%h idx=%0d valid=%b timeout=%b, want all 0",
               grant, grant_idx, grant_valid, timeout);
    end
    // A moved pointer would pick 4 here; an unchanged one (0) picks 3.
    enable = 1'b1;
    req = 16'h0018;
    exp_idx_q.push_back(3);
    tick();
    e = exp_idx_q.pop_front();
    tests_run++;
    if (grant_valid !== 1'b1 || grant_idx !== 4'(e) || grant !== (16'(1) << e)) begin
      tests_failed++;
      $display("FAIL ab_regrant: got idx=%0d grant=%h valid=%b, want idx=%0d", grant_idx, grant, grant_valid, e);
    end
    req = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    int unsigned e;
    do_reset();
    req = 16'h0200;
    exp_idx_q.push_back(9);
    tick();
    e = exp_idx_q.pop_front();
    tests_run++;
    if (grant_valid !== 1'b1 || grant_idx !== 4'(e)) begin
      tests_failed++;
      $display("FAIL rm_grant9: got idx=%0d valid=%b, want idx=%0d valid=1", grant_idx, grant_valid, e);
    end
    tick();
    reset = 1'b1;
    tick();
    tests_run++;
    if (grant !== 16'h0 || grant_idx !== 4'd0 || grant_valid !== 1'b0 || timeout !== 1'b0) begin
      tests_failed++;
      $display("FAIL rm_clear: got grant=%h idx=%0d valid=%b timeout=%b, want all 0",
               grant, grant_idx, grant_valid, timeout);
    end
    tick();
    tests_run++;
    if (grant_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rm_no_grant_in_reset: got valid=%b, want 0", grant_valid);
    end
    reset = 1'b0;
    req = 16'h8001;
    exp_idx_q.push_back(0);
    tick();
    e = exp_idx_q.pop_front();
    tests_run++;
    if (grant_valid !== 1'b1 || grant_idx !== 4'(e) || grant !== 16'h0001) begin
      tests_failed++;
      $display("FAIL rm_after_reset: got idx=%0d grant=%h valid=%b, want idx=0 grant=0001",
               grant_idx, grant, grant_valid);
    end
    req = '0;
    tick();
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    req    = '0;
    test_reset();
    test_round_robin();
    test_wrap();
    test_timeout();
    test_release_at_limit();
    test_abort();
    test_reset_mid();
    tests_run++;
    if (exp_idx_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: got %0d expected grants left, want 0", exp_idx_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
